// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store stage: RV32I funct3 codes, FSM states
// and the store lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

    // Offset bits below the access size are ignored here; trapping on them is
    // decided before the request is ever issued.
    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] offset);
        logic [3:0] strb;
        case (f3)
            F3_SB:   strb = 4'b0001 << offset;
            F3_SH:   strb = offset[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] data;
        case (f3)
            F3_SB:   data = {4{wdata[7:0]}};
            F3_SH:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select plus sign/zero extension of memory read data.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = byte_lane[offset];
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: one memory access at a time over a req/gnt/rvalid port.
// Define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module lsu_stage
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        err_o
);

    lsu_state_e  state_reg, state_next;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  funct3_reg;
    logic [4:0]  rd_reg;
    logic        is_write_reg;
    logic        err_reg;
    logic [31:0] wb_data_reg;

    logic        op_accept;
    logic        op_illegal;
    logic        op_misaligned;
    logic        op_fault;
    logic [31:0] load_result;
    logic        in_req;

    assign op_accept = op_valid_i && (mem_read_i || mem_write_i) &&
                       ((state_reg == IDLE) || (state_reg == DONE));

    assign op_illegal = (mem_read_i && mem_write_i) || !funct3_legal(funct3_i, mem_write_i);

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] distinguishes halfword (01) from word (10) for loads and stores.
    assign op_misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                           ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    assign op_misaligned = 1'b0;
`endif

    assign op_fault = op_illegal || op_misaligned;

    lsu_load_align u_load_align (
        .rdata  (mem_rdata_i),
        .offset (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .result (load_result)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (op_accept) begin
                    state_next = op_fault ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_next = is_write_reg ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (op_accept) begin
                    state_next = op_fault ? DONE : REQ;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            funct3_reg   <= 3'd0;
            rd_reg       <= 5'd0;
            is_write_reg <= 1'b0;
            err_reg      <= 1'b0;
            wb_data_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (op_accept) begin
                addr_reg     <= addr_i;
                wdata_reg    <= wdata_i;
                funct3_reg   <= funct3_i;
                rd_reg       <= rd_i;
                is_write_reg <= mem_write_i;
                err_reg      <= op_fault;
                wb_data_reg  <= 32'd0;
            end else if ((state_reg == WAIT) && mem_rvalid_i) begin
                wb_data_reg <= load_result;
            end
        end
    end

    // Bus outputs are driven only while requesting so nothing stale leaks out.
    assign in_req      = (state_reg == REQ);
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req && is_write_reg;
    assign mem_addr_o  = in_req ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign mem_wstrb_o = (in_req && is_write_reg) ? store_strobe(funct3_reg, addr_reg[1:0]) : 4'd0;
    assign mem_wdata_o = (in_req && is_write_reg) ? store_data(funct3_reg, wdata_reg) : 32'd0;

    assign stall_o    = (state_reg == REQ) || (state_reg == WAIT);
    assign wb_valid_o = (state_reg == DONE);
    assign wb_data_o  = (state_reg == DONE) ? wb_data_reg : 32'd0;
    assign wb_rd_o    = rd_reg;
    assign err_o      = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: vector table with a writeback scoreboard,
// plus hand-written back-to-back and reset-during-access sequences.
module tb_lsu_stage;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        op_valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        err_o;

    lsu_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid_i   (op_valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rd_i         (rd_i),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_data_o    (wb_data_o),
        .wb_rd_o      (wb_rd_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        exp_req;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_wbdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [4:0]  rd;
    } wb_exp_t;

    vec_t    vecs[$];
    wb_exp_t sb_q[$];
    int      checks = 0;
    int      errors = 0;

    function automatic vec_t mk(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                                input logic exp_req, input logic [31:0] exp_maddr,
                                input logic [3:0] exp_strb, input logic [31:0] exp_mwdata,
                                input logic [31:0] exp_wbdata, input logic exp_err);
        vec_t v;
        v.rd_op = rd_op;           v.wr_op = wr_op;       v.f3 = f3;
        v.addr = addr;             v.wdata = wdata;       v.rdata = rdata;
        v.gnt_dly = gnt_dly;       v.rv_dly = rv_dly;     v.exp_req = exp_req;
        v.exp_maddr = exp_maddr;   v.exp_strb = exp_strb; v.exp_mwdata = exp_mwdata;
        v.exp_wbdata = exp_wbdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        op_valid_i  = 1'b1;
        mem_read_i  = rd_op;
        mem_write_i = wr_op;
        funct3_i    = f3;
        addr_i      = addr;
        wdata_i     = wdata;
        rd_i        = rd;
    endtask

    task automatic clear_op();
        op_valid_i  = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
    endtask

    task automatic check_wb(input string name);
        wb_exp_t e;
        check({name, "_wb_valid"}, 32'(wb_valid_o), 32'd1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard actual=empty required=entry", name);
        end else begin
            e = sb_q.pop_front();
            check({name, "_wb_data"}, wb_data_o, e.data);
            check({name, "_err"}, 32'(err_o), 32'(e.err));
            check({name, "_rd"}, 32'(wb_rd_o), 32'(e.rd));
            $display("txn %s wb_data=%h err=%0d rd=%0d", name, wb_data_o, err_o, wb_rd_o);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        logic [4:0] rd;
        nm = $sformatf("v%0d", idx);
        rd = 5'(idx + 1);
        @(negedge clk);
        drive_op(v.rd_op, v.wr_op, v.f3, v.addr, v.wdata, rd);
        mem_rdata_i = v.rdata;
        sb_q.push_back('{data: v.exp_wbdata, err: v.exp_err, rd: rd});
        @(negedge clk);
        clear_op();
        if (v.exp_req) begin
            for (int k = 0; k <= v.gnt_dly; k++) begin
                check({nm, "_req"}, 32'(mem_req_o), 32'd1);
                check({nm, "_stall"}, 32'(stall_o), 32'd1);
                check({nm, "_we"}, 32'(mem_we_o), 32'(v.wr_op));
                check({nm, "_maddr"}, mem_addr_o, v.exp_maddr);
                check({nm, "_wstrb"}, 32'(mem_wstrb_o), 32'(v.exp_strb));
                check({nm, "_mwdata"}, mem_wdata_o, v.exp_mwdata);
                check({nm, "_early_wb"}, 32'(wb_valid_o), 32'd0);
                mem_gnt_i = (k == v.gnt_dly);
                @(negedge clk);
            end
            mem_gnt_i = 1'b0;
            if (v.rd_op) begin
                for (int k = 0; k <= v.rv_dly; k++) begin
                    check({nm, "_wait_stall"}, 32'(stall_o), 32'd1);
                    check({nm, "_wait_req"}, 32'(mem_req_o), 32'd0);
                    mem_rvalid_i = (k == v.rv_dly);
                    @(negedge clk);
                end
                mem_rvalid_i = 1'b0;
            end
        end else begin
            check({nm, "_noreq"}, 32'(mem_req_o), 32'd0);
            check({nm, "_nostall"}, 32'(stall_o), 32'd0);
        end
        check_wb(nm);
        @(negedge clk);
        check({nm, "_wb_once"}, 32'(wb_valid_o), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_req"}, 32'(mem_req_o), 32'd0);
        check({name, "_stall"}, 32'(stall_o), 32'd0);
        check({name, "_we"}, 32'(mem_we_o), 32'd0);
        check({name, "_maddr"}, mem_addr_o, 32'd0);
        check({name, "_mwdata"}, mem_wdata_o, 32'd0);
        check({name, "_wstrb"}, 32'(mem_wstrb_o), 32'd0);
        check({name, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
        check({name, "_wb_data"}, wb_data_o, 32'd0);
        check({name, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
        check({name, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        clear_op();
        funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0; rd_i = 5'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;

        vecs.push_back(mk(0, 1, F3_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk(1, 0, F3_LB,  32'h103, 32'h0,        32'h80FFFF00, 0, 0, 1, 32'h100, 4'h0, 32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(mk(1, 0, F3_LBU, 32'h103, 32'h0,        32'h80FFFF00, 0, 0, 1, 32'h100, 4'h0, 32'h0,        32'h00000080, 0));
        vecs.push_back(mk(0, 1, F3_SH,  32'h22,  32'h00001234, 32'h0,        0, 0, 1, 32'h20,  4'hC, 32'h12341234, 32'h0,        0));
        vecs.push_back(mk(0, 1, F3_SB,  32'h41,  32'h000000A5, 32'h0,        3, 0, 1, 32'h40,  4'h2, 32'hA5A5A5A5, 32'h0,        0));
        vecs.push_back(mk(1, 0, F3_LH,  32'h52,  32'h0,        32'h80017FFF, 0, 2, 1, 32'h50,  4'h0, 32'h0,        32'hFFFF8001, 0));
        vecs.push_back(mk(1, 0, F3_LHU, 32'h52,  32'h0,        32'h80017FFF, 0, 0, 1, 32'h50,  4'h0, 32'h0,        32'h00008001, 0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(1, 0, F3_LW,  32'h101, 32'h0,        32'hCAFEF00D, 1, 1, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(1, 0, F3_LH,  32'h51,  32'h0,        32'h80017FFF, 0, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 1, F3_SW,  32'h7,   32'hCAFE0001, 32'h0,        0, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1));
`else
        vecs.push_back(mk(1, 0, F3_LW,  32'h101, 32'h0,        32'hCAFEF00D, 1, 1, 1, 32'h100, 4'h0, 32'h0,        32'hCAFEF00D, 0));
        vecs.push_back(mk(1, 0, F3_LH,  32'h51,  32'h0,        32'h80017FFF, 0, 0, 1, 32'h50,  4'h0, 32'h0,        32'h00007FFF, 0));
        vecs.push_back(mk(0, 1, F3_SW,  32'h7,   32'hCAFE0001, 32'h0,        0, 0, 1, 32'h4,   4'hF, 32'hCAFE0001, 32'h0,        0));
`endif
        vecs.push_back(mk(1, 0, 3'b011, 32'h10,  32'h0,        32'h12345678, 0, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 1, 3'b100, 32'h10,  32'h55555555, 32'h0,        0, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(1, 1, F3_LW,  32'h10,  32'h0,        32'h12345678, 0, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(1, 0, F3_LB,  32'h61,  32'h0,        32'h00007F00, 1, 1, 1, 32'h60,  4'h0, 32'h0,        32'h0000007F, 0));
        vecs.push_back(mk(1, 0, F3_LHU, 32'h2,   32'h0,        32'hABCD1234, 0, 0, 1, 32'h0,   4'h0, 32'h0,        32'h0000ABCD, 0));
        vecs.push_back(mk(0, 1, F3_SB,  32'h3,   32'h123456FE, 32'h0,        0, 0, 1, 32'h0,   4'h8, 32'hFEFEFEFE, 32'h0,        0));

        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back: a load presented in the DONE cycle of a store.
        @(negedge clk);
        drive_op(0, 1, F3_SW, 32'h200, 32'h01020304, 5'd20);
        sb_q.push_back('{data: 32'h0, err: 1'b0, rd: 5'd20});
        @(negedge clk);
        clear_op();
        check("b2b_st_req", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check_wb("b2b_st");
        drive_op(1, 0, F3_LW, 32'h204, 32'h0, 5'd21);
        mem_rdata_i = 32'h11223344;
        sb_q.push_back('{data: 32'h11223344, err: 1'b0, rd: 5'd21});
        @(negedge clk);
        clear_op();
        check("b2b_ld_req", 32'(mem_req_o), 32'd1);
        check("b2b_ld_maddr", mem_addr_o, 32'h204);
        check("b2b_ld_we", 32'(mem_we_o), 32'd0);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        check_wb("b2b_ld");
        @(negedge clk);
        check("b2b_idle", 32'(wb_valid_o), 32'd0);

        // Reset while requesting drops the request immediately.
        drive_op(1, 0, F3_LW, 32'h300, 32'h0, 5'd5);
        @(negedge clk);
        clear_op();
        check("rstreq_req_before", 32'(mem_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rstreq");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while waiting for read data; the late rvalid must be ignored.
        @(negedge clk);
        drive_op(1, 0, F3_LW, 32'h300, 32'h0, 5'd6);
        @(negedge clk);
        clear_op();
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check("rstwait_stall_before", 32'(stall_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstwait_stall", 32'(stall_o), 32'd0);
        check("rstwait_req", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rdata_i = 32'h99999999;
        mem_rvalid_i = 1'b1;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rstwait_no_wb", 32'(wb_valid_o), 32'd0);
            check("rstwait_no_stall", 32'(stall_o), 32'd0);
            @(negedge clk);
        end
        $display("txn reset_in_wait abandoned wb_valid=%0d", wb_valid_o);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
